// File: rtl/branch_predict_nway_pkg.sv
// Shared types and helpers for the N-lane local-history branch predictor (package bp_pkg).
// Optional statistics counters in the top are enabled with BRANCH_PRED_STATS_EN.
package bp_pkg;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_SNT = 2'b00;
    localparam cnt_t CNT_WNT = 2'b01;
    localparam cnt_t CNT_WT  = 2'b10;
    localparam cnt_t CNT_ST  = 2'b11;

    localparam logic [5:0] OP_REGIMM    = 6'b000001;
    localparam logic [3:0] OP_BRANCH_HI = 4'b0001;

    typedef enum logic {ST_INIT, ST_RUN} fsm_state_t;

    function automatic cnt_t sat_step(cnt_t c, logic take);
        if (take)
            return (c == CNT_ST) ? CNT_ST : c + 2'd1;
        else
            return (c == CNT_SNT) ? CNT_SNT : c - 2'd1;
    endfunction

    // REGIMM with rt[4:2] of 000/001 (bltz/bgez family) or beq/bne/blez/bgtz.
    function automatic logic is_branch(logic [31:0] instr);
        logic [5:0] op;
        logic [2:0] rt_hi;
        logic       unused_bits;
        op          = instr[31:26];
        rt_hi       = instr[20:18];
        unused_bits = ^{instr[25:21], instr[17:0]};
        return ((op == OP_REGIMM) && ((rt_hi == 3'b000) || (rt_hi == 3'b001)))
            || (op[5:2] == OP_BRANCH_HI);
    endfunction

endpackage

// File: rtl/branch_predict_nway_init_fsm.sv
// INIT/RUN sequencer: sweeps init_idx over every table entry after reset, then enters RUN.
module bp_init_fsm
    import bp_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] init_idx,
    output logic             init_busy
);

    fsm_state_t       state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_INIT;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        if (state_reg == ST_INIT) begin
            idx_next = idx_reg + IDX_W'(1);
            if (&idx_reg)
                state_next = ST_RUN;
        end
    end

    assign init_idx  = idx_reg;
    assign init_busy = (state_reg == ST_INIT);

endmodule

// File: rtl/branch_predict_nway.sv
// N-lane two-level local-history predictor: lookup in F2, registered into D, trained from E.
// Define BRANCH_PRED_STATS_EN to add pred_takeE input and br_cnt/mispred_cnt counters.
module branch_predict_nway
    import bp_pkg::*;
#(
    parameter int ISSUE_W   = 2,
    parameter int BHT_DEPTH = 10,
    parameter int HIST_LEN  = 6,
    parameter int PHT_DEPTH = 6,
    parameter int IDX_HASH  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            pcF2,
    input  logic [ISSUE_W-1:0]     stallD,
    input  logic [ISSUE_W-1:0]     flushD,
    input  logic [32*ISSUE_W-1:0]  instrD,
    input  logic [32*ISSUE_W-1:0]  pcE,
    input  logic [ISSUE_W-1:0]     branchE,
    input  logic [ISSUE_W-1:0]     actual_takeE,
`ifdef BRANCH_PRED_STATS_EN
    input  logic [ISSUE_W-1:0]     pred_takeE,
    output logic [31:0]            br_cnt,
    output logic [31:0]            mispred_cnt,
`endif
    output logic [ISSUE_W-1:0]     branchD,
    output logic [ISSUE_W-1:0]     pred_takeD,
    output logic                   init_busy
);

    localparam int IDX_W = (BHT_DEPTH > PHT_DEPTH) ? BHT_DEPTH : PHT_DEPTH;

    typedef logic [HIST_LEN-1:0]  hist_t;
    typedef logic [BHT_DEPTH-1:0] bidx_t;
    typedef logic [PHT_DEPTH-1:0] pidx_t;

    hist_t bht [2**BHT_DEPTH];
    cnt_t  pht [2**PHT_DEPTH];

    logic [IDX_W-1:0]   init_idx;
    logic [ISSUE_W-1:0] pred_f2;
    logic [ISSUE_W-1:0] pred_d_reg;
    bidx_t              upd_bidx [ISSUE_W];
    pidx_t              upd_pidx [ISSUE_W];
    hist_t              upd_hist [ISSUE_W];
    cnt_t               upd_cnt  [ISSUE_W];
    logic               unused_ok;

    function automatic pidx_t pht_index(hist_t h, pidx_t pc_bits);
        pidx_t idx;
        idx = '0;
        idx[HIST_LEN-1:0] = h;
        return idx ^ ((IDX_HASH != 0) ? pc_bits : '0);
    endfunction

    bp_init_fsm #(.IDX_W(IDX_W)) u_init_fsm (
        .clk       (clk),
        .rst       (rst),
        .init_idx  (init_idx),
        .init_busy (init_busy)
    );

    for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_lane
        logic [31:0] pc_l;
        hist_t       h_l;
        hist_t       h_e;
        logic        unused_pc_l;

        assign pc_l        = pcF2 + 32'(4 * gi);
        assign unused_pc_l = ^pc_l;
        assign h_l         = bht[pc_l[BHT_DEPTH+1:2]];
        assign pred_f2[gi] = !init_busy && pht[pht_index(h_l, pc_l[PHT_DEPTH+1:2])][1];

        assign branchD[gi]    = is_branch(instrD[32*gi +: 32]);
        assign pred_takeD[gi] = branchD[gi] & pred_d_reg[gi];

        assign upd_bidx[gi] = pcE[32*gi+2 +: BHT_DEPTH];
        assign h_e          = bht[upd_bidx[gi]];
        assign upd_pidx[gi] = pht_index(h_e, pcE[32*gi+2 +: PHT_DEPTH]);

        // Fold in every older-or-equal lane hitting the same entry so the last writer holds the full result.
        always_comb begin
            hist_t h;
            cnt_t  c;
            h = h_e;
            c = pht[upd_pidx[gi]];
            for (int j = 0; j <= gi; j++) begin
                if (branchE[j] && (upd_bidx[j] == upd_bidx[gi]))
                    h = {h[HIST_LEN-2:0], actual_takeE[j]};
                if (branchE[j] && (upd_pidx[j] == upd_pidx[gi]))
                    c = sat_step(c, actual_takeE[j]);
            end
            upd_hist[gi] = h;
            upd_cnt[gi]  = c;
        end
    end

    always_ff @(posedge clk) begin
        if (init_busy) begin
            bht[init_idx[BHT_DEPTH-1:0]] <= '0;
            pht[init_idx[PHT_DEPTH-1:0]] <= CNT_WNT;
        end else begin
            for (int i = 0; i < ISSUE_W; i++) begin
                if (branchE[i]) begin
                    bht[upd_bidx[i]] <= upd_hist[i];
                    pht[upd_pidx[i]] <= upd_cnt[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pred_d_reg <= '0;
        end else begin
            for (int i = 0; i < ISSUE_W; i++) begin
                if (flushD[i])
                    pred_d_reg[i] <= 1'b0;
                else if (!stallD[i])
                    pred_d_reg[i] <= pred_f2[i];
            end
        end
    end

`ifdef BRANCH_PRED_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt      <= '0;
            mispred_cnt <= '0;
        end else if (!init_busy) begin
            br_cnt      <= br_cnt + 32'($countones(branchE));
            mispred_cnt <= mispred_cnt + 32'($countones(branchE & (pred_takeE ^ actual_takeE)));
        end
    end
`endif

    assign unused_ok = ^{pcF2, pcE, instrD, init_idx};

endmodule
